pipe_stage_skid: RTL and testbench

//  - Parametrised elastic pipeline-stage register for the pipelined CPU: replaces the bare fixed-size stage register between stages.
//  - Adds valid/ready handshake, synchronous flush and a 2-entry skid buffer, so the stage runs at full throughput with registered ready.
//  - Each instance (IF/ID, ID/EX, EX/MEM, MEM/WB) carries an arbitrary-width packed bundle of datapath and control fields.

---
 rtl/pipe_pkg.sv | 13 +
 rtl/pipe_sat_counter.sv | 20 ++
 rtl/pipe_stage_skid.sv | 114 +++++++++++
 tb/tb_pipe_stage_skid.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types: occupancy encoding and the default counter width
// used by every stage instance and the hazard/forwarding logic.
package pipe_pkg;

  localparam int unsigned PIPE_CNT_W = 16;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } pipe_occ_e;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts qualifying cycles, sticks at all-ones,
// cleared only by the synchronous reset.
module pipe_sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with valid/ready handshake, flush and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add the stall/bubble performance counters.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned          DATA_W     = 64,
  parameter logic [DATA_W-1:0]    RESET_DATA = '0,
  parameter int unsigned          CNT_W      = PIPE_CNT_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              up_valid_i,
  output logic              up_ready_o,
  input  logic [DATA_W-1:0] up_data_i,
  output logic              dn_valid_o,
  input  logic              dn_ready_i,
  output logic [DATA_W-1:0] dn_data_o,
`ifdef PIPE_STAGE_PERF_EN
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  bubble_cnt_o,
`endif
  output logic [1:0]        occupancy_o
);

  pipe_occ_e         state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              up_ready_q, dn_valid_q;
  logic              up_xfer, dn_xfer;

  assign up_ready_o  = up_ready_q;
  assign dn_valid_o  = dn_valid_q;
  assign dn_data_o   = main_q;
  assign occupancy_o = state_q;

  assign up_xfer = up_valid_i && up_ready_q;
  assign dn_xfer = dn_valid_q && dn_ready_i;

  // Main reg always holds the oldest beat; skid only fills when the stage stalls with one held.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      OCC_EMPTY: begin
        if (up_xfer) begin
          state_d = OCC_ONE;
          main_d  = up_data_i;
        end
      end
      OCC_ONE: begin
        if (up_xfer && dn_xfer) begin
          main_d = up_data_i;
        end else if (dn_xfer) begin
          state_d = OCC_EMPTY;
        end else if (up_xfer) begin
          state_d = OCC_FULL;
          skid_d  = up_data_i;
        end
      end
      OCC_FULL: begin
        if (dn_xfer) begin
          state_d = OCC_ONE;
          main_d  = skid_q;
        end
      end
      default: begin
        state_d = OCC_EMPTY;
      end
    endcase
    if (flush_i) begin
      state_d = OCC_EMPTY;
      main_d  = RESET_DATA;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= OCC_EMPTY;
      main_q     <= RESET_DATA;
      skid_q     <= RESET_DATA;
      up_ready_q <= 1'b1;
      dn_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      up_ready_q <= (state_d != OCC_FULL);
      dn_valid_q <= (state_d != OCC_EMPTY);
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (dn_valid_q && !dn_ready_i),
    .cnt_o (stall_cnt_o)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (!dn_valid_q && dn_ready_i),
    .cnt_o (bubble_cnt_o)
  );
`else
  // Keeps CNT_W referenced when the counters are compiled out.
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: directed scenarios plus random traffic
// against a queue-based FIFO model of the stage.
module tb_pipe_stage_skid;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, up_valid, dn_ready;
  logic [DATA_W-1:0] up_data, dn_data;
  logic              up_ready, dn_valid;
  logic [1:0]        occ;
`ifdef PIPE_STAGE_PERF_EN
  logic [CNT_W-1:0]  stall_cnt, bubble_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_out;
  int                m_stall, m_bubble;
  bit                m_up_xfer;

  always #5 clk = ~clk;

  pipe_stage_skid #(
    .DATA_W(DATA_W), .RESET_DATA('0), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .up_valid_i(up_valid), .up_ready_o(up_ready), .up_data_i(up_data),
    .dn_valid_o(dn_valid), .dn_ready_i(dn_ready), .dn_data_o(dn_data),
`ifdef PIPE_STAGE_PERF_EN
    .stall_cnt_o(stall_cnt), .bubble_cnt_o(bubble_cnt),
`endif
    .occupancy_o(occ)
  );

  // One clock: drive inputs, advance the FIFO model, leave sampling time 1 after the edge.
  task automatic cycle(input bit uv, input logic [DATA_W-1:0] ud, input bit dr,
                       input bit fl, input bit rs);
    bit dn_x, st_inc, bu_inc;
    up_valid = uv; up_data = ud; dn_ready = dr; flush = fl; rst = rs;
    m_up_xfer = uv && (mq.size() < 2);
    dn_x      = (mq.size() > 0) && dr;
    st_inc    = (mq.size() > 0) && !dr;
    bu_inc    = (mq.size() == 0) && dr;
    @(posedge clk);
    if (rs) begin
      mq.delete(); m_out = '0; m_stall = 0; m_bubble = 0;
    end else begin
      if (st_inc && m_stall < CNT_MAX) m_stall++;
      if (bu_inc && m_bubble < CNT_MAX) m_bubble++;
      if (fl) begin
        mq.delete(); m_out = '0;
      end else begin
        if (dn_x) void'(mq.pop_front());
        if (m_up_xfer) mq.push_back(ud);
        if (mq.size() > 0) m_out = mq[0];
      end
    end
    #1;
  endtask

  task automatic test_reset();
    cycle(1, 32'hDEAD, 0, 0, 1);
    cycle(1, 32'hDEAD, 0, 0, 1);
    n_checks++; if (dn_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dn_valid got %b want 0", dn_valid); end
    n_checks++; if (dn_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_dn_data got %h want 0", dn_data); end
    n_checks++; if (up_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_up_ready got %b want 1", up_ready); end
    n_checks++; if (occ !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_occ got %0d want 0", occ); end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++; if (stall_cnt !== '0 || bubble_cnt !== '0) begin n_fail++;
      $display("[TB] FAIL reset_counters got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
`endif
  endtask

  task automatic test_streaming();
    for (int i = 1; i <= 8; i++) begin
      cycle(1, DATA_W'(i), 1, 0, 0);
      n_checks++; if (dn_valid !== 1'b1 || dn_data !== DATA_W'(i)) begin n_fail++;
        $display("[TB] FAIL stream_beat%0d got v=%b d=%h want v=1 d=%h", i, dn_valid, dn_data, i); end
      n_checks++; if (up_ready !== 1'b1) begin n_fail++;
        $display("[TB] FAIL stream_ready%0d got %b want 1", i, up_ready); end
    end
    cycle(0, '0, 1, 0, 0);
    n_checks++; if (occ !== 2'd0 || dn_valid !== 1'b0) begin n_fail++;
      $display("[TB] FAIL stream_drain got occ=%0d v=%b want occ=0 v=0", occ, dn_valid); end
  endtask

  task automatic test_backpressure();
    int stall0;
    stall0 = m_stall;
    cycle(1, 32'hA, 0, 0, 0);
    cycle(1, 32'hB, 0, 0, 0);
    cycle(1, 32'hC, 0, 0, 0);
    n_checks++; if (occ !== 2'd2 || up_ready !== 1'b0) begin n_fail++;
      $display("[TB] FAIL bp_full got occ=%0d rdy=%b want occ=2 rdy=0", occ, up_ready); end
    n_checks++; if (dn_data !== 32'hA) begin n_fail++; $display("[TB] FAIL bp_out0 got %h want a", dn_data); end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++; if (int'(stall_cnt) !== stall0 + 2) begin n_fail++;
      $display("[TB] FAIL bp_stall_cnt got %0d want %0d", stall_cnt, stall0 + 2); end
`endif
    cycle(1, 32'hC, 1, 0, 0);
    n_checks++; if (dn_data !== 32'hB || occ !== 2'd1 || up_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL bp_out1 got d=%h occ=%0d rdy=%b want d=b occ=1 rdy=1", dn_data, occ, up_ready); end
    cycle(1, 32'hC, 1, 0, 0);
    n_checks++; if (dn_data !== 32'hC || dn_valid !== 1'b1) begin n_fail++;
      $display("[TB] FAIL bp_out2 got d=%h v=%b want d=c v=1", dn_data, dn_valid); end
    cycle(0, '0, 1, 0, 0);
  endtask

  task automatic test_flush();
    cycle(1, 32'h11, 0, 0, 0);
    cycle(1, 32'h22, 0, 0, 0);
    n_checks++; if (occ !== 2'd2) begin n_fail++; $display("[TB] FAIL flush_pre_occ got %0d want 2", occ); end
    cycle(1, 32'h55, 0, 1, 0);
    n_checks++; if (dn_valid !== 1'b0 || occ !== 2'd0 || up_ready !== 1'b1 || dn_data !== 32'h0) begin n_fail++;
      $display("[TB] FAIL flush_full got v=%b occ=%0d rdy=%b d=%h want 0 0 1 0", dn_valid, occ, up_ready, dn_data); end
    cycle(1, 32'h66, 0, 0, 0);
    cycle(1, 32'h55, 1, 1, 0);
    n_checks++; if (dn_valid !== 1'b0 || occ !== 2'd0) begin n_fail++;
      $display("[TB] FAIL flush_one got v=%b occ=%0d want 0 0", dn_valid, occ); end
    for (int i = 0; i < 3; i++) begin
      cycle(0, '0, 1, 0, 0);
      n_checks++; if (dn_valid !== 1'b0 || dn_data === 32'h55) begin n_fail++;
        $display("[TB] FAIL flush_leak%0d got v=%b d=%h want v=0", i, dn_valid, dn_data); end
    end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++; if (int'(stall_cnt) !== m_stall) begin n_fail++;
      $display("[TB] FAIL flush_keeps_stall got %0d want %0d", stall_cnt, m_stall); end
`endif
  endtask

  task automatic test_bubble_sat();
    for (int i = 0; i < 20; i++) cycle(0, '0, 1, 0, 0);
`ifdef PIPE_STAGE_PERF_EN
    n_checks++; if (bubble_cnt !== 4'hF) begin n_fail++; $display("[TB] FAIL bubble_sat got %h want f", bubble_cnt); end
    cycle(0, '0, 0, 1, 0);
    n_checks++; if (bubble_cnt !== 4'hF) begin n_fail++; $display("[TB] FAIL bubble_flush got %h want f", bubble_cnt); end
`endif
    cycle(0, '0, 1, 0, 1);
    n_checks++; if (occ !== 2'd0 || up_ready !== 1'b1) begin n_fail++;
      $display("[TB] FAIL bubble_reset_state got occ=%0d rdy=%b want 0 1", occ, up_ready); end
`ifdef PIPE_STAGE_PERF_EN
    n_checks++; if (bubble_cnt !== 4'h0 || stall_cnt !== 4'h0) begin n_fail++;
      $display("[TB] FAIL bubble_reset got %h/%h want 0/0", bubble_cnt, stall_cnt); end
`endif
  endtask

  task automatic test_simultaneous();
    cycle(1, 32'h10, 0, 0, 0);
    n_checks++; if (dn_data !== 32'h10 || occ !== 2'd1) begin n_fail++;
      $display("[TB] FAIL simul_load got d=%h occ=%0d want 10 1", dn_data, occ); end
    cycle(1, 32'h20, 1, 0, 0);
    n_checks++; if (dn_data !== 32'h20 || occ !== 2'd1 || dn_valid !== 1'b1) begin n_fail++;
      $display("[TB] FAIL simul_swap got d=%h occ=%0d v=%b want 20 1 1", dn_data, occ, dn_valid); end
    cycle(0, '0, 1, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle(bit'($urandom_range(0, 2) != 0), $urandom, bit'($urandom_range(0, 9) < 6),
            bit'($urandom_range(0, 29) == 0), bit'($urandom_range(0, 149) == 0));
      n_checks++; if (occ !== 2'(mq.size()) || dn_valid !== (mq.size() > 0) || up_ready !== (mq.size() < 2)) begin
        n_fail++; $display("[TB] FAIL rand_state%0d got occ=%0d v=%b rdy=%b want occ=%0d", i, occ, dn_valid, up_ready, mq.size()); end
      n_checks++; if (dn_data !== m_out) begin n_fail++;
        $display("[TB] FAIL rand_data%0d got %h want %h", i, dn_data, m_out); end
`ifdef PIPE_STAGE_PERF_EN
      n_checks++; if (int'(stall_cnt) !== m_stall || int'(bubble_cnt) !== m_bubble) begin n_fail++;
        $display("[TB] FAIL rand_cnt%0d got %0d/%0d want %0d/%0d", i, stall_cnt, bubble_cnt, m_stall, m_bubble); end
`endif
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b0; up_data = '0;
    m_out = '0; m_stall = 0; m_bubble = 0; m_up_xfer = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_bubble_sat();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
